// File: rtl/alarm_clock_core.sv
// alarm_clock_core: 24-hour timekeeping with button-adjustable time and
// alarm registers, a ring/snooze/timeout alarm machine, and BCD digit
// outputs for the downstream digit mux.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | alarm silent; waiting for time to reach the alarm hh:mm:00
// RINGING | alarm sounding; ring-seconds counter running down
// SNOOZED | silent; waiting for time to reach the snooze target hh:mm:00
module alarm_clock_core #(
  parameter int TICK_DIV   = 100000000,
  parameter int H12        = 0,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       set_alarm,
  input  logic       inc_min,
  input  logic       dec_min,
  input  logic       inc_hour,
  input  logic       dec_hour,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_units,
  output logic [2:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       pm,
  output logic       ringing,
  output logic       sec_tick
);

  localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [7:0]      RING_LOAD = 8'(RING_SEC);
  localparam logic [6:0]      SNZ_ADD   = 7'(SNOOZE_MIN);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc;
  logic [4:0]    t_hour, nxt_hour, a_hour, nxt_a_hour, snz_hour, snz_hour_calc;
  logic [5:0]    t_min, nxt_min, a_min, nxt_a_min, snz_min, snz_min_calc;
  logic [5:0]    t_sec, nxt_sec;
  logic [6:0]    snz_sum;
  logic [7:0]    ring_cnt;
  logic          time_edit, alarm_hit, snz_hit;
  logic          ring_load, ring_dec, snz_load;
  logic [4:0]    disp_hour, shown_hour;
  logic [5:0]    disp_min, disp_sec;
  logic [6:0]    hr_bcd, min_bcd, sec_bcd;

  // Split 0..59 into tens and units by repeated subtraction of ten.
  function automatic logic [6:0] to_bcd(input logic [5:0] v);
    logic [2:0] t;
    logic [5:0] u;
    t = 3'd0;
    u = v;
    for (int i = 0; i < 5; i++) begin
      if (u >= 6'd10) begin
        u = u - 6'd10;
        t = t + 3'd1;
      end
    end
    return {t, 4'(u)};
  endfunction

  assign time_edit = !run && !set_alarm;
  assign sec_tick  = run && (presc == PRESC_MAX);

  // Prescaler: free-runs while run=1, held at zero otherwise so a stop
  // discards any partial second.
  always_ff @(posedge clk) begin
    if (!reset)                           presc <= '0;
    else if (!run || presc == PRESC_MAX)  presc <= '0;
    else                                  presc <= presc + 1'b1;
  end

  // Next time value: second tick with carries, or a manual edit without carries.
  always_comb begin
    nxt_sec  = t_sec;
    nxt_min  = t_min;
    nxt_hour = t_hour;
    if (sec_tick) begin
      if (t_sec == 6'd59) begin
        nxt_sec = 6'd0;
        if (t_min == 6'd59) begin
          nxt_min  = 6'd0;
          nxt_hour = (t_hour == 5'd23) ? 5'd0 : t_hour + 5'd1;
        end else begin
          nxt_min = t_min + 6'd1;
        end
      end else begin
        nxt_sec = t_sec + 6'd1;
      end
    end else if (time_edit) begin
      if (inc_min)      nxt_min = (t_min == 6'd59) ? 6'd0 : t_min + 6'd1;
      else if (dec_min) nxt_min = (t_min == 6'd0) ? 6'd59 : t_min - 6'd1;
      if (inc_min || dec_min) nxt_sec = 6'd0;
      if (inc_hour)      nxt_hour = (t_hour == 5'd23) ? 5'd0 : t_hour + 5'd1;
      else if (dec_hour) nxt_hour = (t_hour == 5'd0) ? 5'd23 : t_hour - 5'd1;
    end
  end

  // Next alarm value: adjust pulses apply whenever the alarm is selected.
  always_comb begin
    nxt_a_min  = a_min;
    nxt_a_hour = a_hour;
    if (set_alarm) begin
      if (inc_min)      nxt_a_min = (a_min == 6'd59) ? 6'd0 : a_min + 6'd1;
      else if (dec_min) nxt_a_min = (a_min == 6'd0) ? 6'd59 : a_min - 6'd1;
      if (inc_hour)      nxt_a_hour = (a_hour == 5'd23) ? 5'd0 : a_hour + 5'd1;
      else if (dec_hour) nxt_a_hour = (a_hour == 5'd0) ? 5'd23 : a_hour - 5'd1;
    end
  end

  // Time and alarm registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      t_hour <= 5'd0;
      t_min  <= 6'd0;
      t_sec  <= 6'd0;
      a_hour <= 5'd0;
      a_min  <= 6'd0;
    end else begin
      t_hour <= nxt_hour;
      t_min  <= nxt_min;
      t_sec  <= nxt_sec;
      a_hour <= nxt_a_hour;
      a_min  <= nxt_a_min;
    end
  end

  // Snooze target = current hh:mm + SNOOZE_MIN; at most one hour carry.
  always_comb begin
    snz_sum       = {1'b0, t_min} + SNZ_ADD;
    snz_min_calc  = snz_sum[5:0];
    snz_hour_calc = t_hour;
    if (snz_sum >= 7'd60) begin
      snz_min_calc  = 6'(snz_sum - 7'd60);
      snz_hour_calc = (t_hour == 5'd23) ? 5'd0 : t_hour + 5'd1;
    end
  end

  // Matches are taken against the post-tick time so ringing rises together
  // with the new digits; manual edits never produce a hit.
  assign alarm_hit = sec_tick && (nxt_hour == a_hour) && (nxt_min == a_min)
                     && (nxt_sec == 6'd0);
  assign snz_hit   = sec_tick && (nxt_hour == snz_hour) && (nxt_min == snz_min)
                     && (nxt_sec == 6'd0);

  // Alarm FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Alarm FSM next state; alarm_en low overrides everything, stop beats snooze.
  always_comb begin
    state_d   = state_q;
    ring_load = 1'b0;
    ring_dec  = 1'b0;
    snz_load  = 1'b0;
    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_hit) begin
            state_d   = RINGING;
            ring_load = 1'b1;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snooze) begin
            state_d  = SNOOZED;
            snz_load = 1'b1;
          end else if (sec_tick) begin
            if (ring_cnt == 8'd1) state_d  = IDLE;
            else                  ring_dec = 1'b1;
          end
        end
        SNOOZED: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snz_hit) begin
            state_d   = RINGING;
            ring_load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Ring timeout down-counter and captured snooze target.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ring_cnt <= 8'd0;
      snz_hour <= 5'd0;
      snz_min  <= 6'd0;
    end else begin
      if (ring_load)     ring_cnt <= RING_LOAD;
      else if (ring_dec) ring_cnt <= ring_cnt - 8'd1;
      if (snz_load) begin
        snz_hour <= snz_hour_calc;
        snz_min  <= snz_min_calc;
      end
    end
  end

  assign ringing = (state_q == RINGING);

  // Display select and optional 12-hour conversion; storage stays 24 h.
  always_comb begin
    disp_hour = set_alarm ? a_hour : t_hour;
    disp_min  = set_alarm ? a_min  : t_min;
    disp_sec  = set_alarm ? 6'd0   : t_sec;
    pm        = (disp_hour >= 5'd12);
    shown_hour = disp_hour;
    if (H12 != 0) begin
      if (disp_hour == 5'd0)       shown_hour = 5'd12;
      else if (disp_hour > 5'd12)  shown_hour = disp_hour - 5'd12;
    end
    hr_bcd  = to_bcd({1'b0, shown_hour});
    min_bcd = to_bcd(disp_min);
    sec_bcd = to_bcd(disp_sec);
  end

  assign hr_tens   = 2'(hr_bcd[6:4]);
  assign hr_units  = hr_bcd[3:0];
  assign min_tens  = min_bcd[6:4];
  assign min_units = min_bcd[3:0];
  assign sec_tens  = sec_bcd[6:4];
  assign sec_units = sec_bcd[3:0];

endmodule
